rf_write_sched: RTL and testbench

- Write-port scheduler and hazard scoreboard for the 16-entry RegFile.
- Shares the single RegFile write port between three writeback sources: load data, ALU result and immediate load.
  - Arbitration is fixed-priority with anti-starvation aging.
  - The granted write is registered and driven to RegFile one cycle later.
- A per-register busy scoreboard tracks issued-but-uncommitted destinations and stalls decode on RAW/WAW hazards.

---
 rtl/rf_write_sched_pkg.sv | 15 +
 rtl/rf_scoreboard.sv | 46 ++++
 rtl/rf_write_sched.sv | 112 +++++++++++
 tb/tb_rf_write_sched.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/rf_write_sched_pkg.sv
// Shared definitions for the RegFile write-port scheduler: requester
// indices and the aging threshold used for anti-starvation promotion.
package rf_write_sched_pkg;

    localparam int kNREQ    = 3;
    localparam int kAGE_MAX = 3;

    // Fixed-priority order: lower index wins unless another requester has aged out.
    typedef enum logic [1:0] {
        REQ_LOAD = 2'd0,
        REQ_ALU  = 2'd1,
        REQ_IMM  = 2'd2
    } req_idx_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: tracks issued-but-uncommitted destinations
// and rejects issues that would read or overwrite a pending register.
module rf_scoreboard
#(
    parameter int D = 4
)
(
    input  logic           Clk,
    input  logic           Reset_n,
    input  logic           IssueEn,
    input  logic [D-1:0]   IssueAddr,
    input  logic [D-1:0]   ReadAddrA,
    input  logic [D-1:0]   ReadAddrB,
    input  logic           CommitEn,
    input  logic [D-1:0]   CommitAddr,
    output logic           Stall,
    output logic [2**D-1:0] Busy
);

    localparam int NR = 2**D;

    logic [NR-1:0] busy_q;
    logic [NR-1:0] busy_d;

    // A committing register still reads stale data this cycle, so it stalls too.
    assign Stall = IssueEn & (busy_q[ReadAddrA] | busy_q[ReadAddrB] | busy_q[IssueAddr]);

    always_comb begin
        busy_d = busy_q;
        if (CommitEn)
            busy_d[CommitAddr] = 1'b0;
        // Applied after the clear so a same-register issue wins.
        if (IssueEn && !Stall)
            busy_d[IssueAddr] = 1'b1;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            busy_q <= '0;
        else
            busy_q <= busy_d;
    end

    assign Busy = busy_q;

endmodule

// File: rtl/rf_write_sched.sv
// RegFile write-port scheduler: fixed-priority arbitration with aging over
// the writeback sources, a one-stage registered write port, and the scoreboard.
module rf_write_sched
    import rf_write_sched_pkg::*;
#(
    parameter int W       = 8,
    parameter int D       = 4,
    parameter int NREQ    = kNREQ,
    parameter int AGE_MAX = kAGE_MAX
)
(
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [NREQ-1:0]   ReqValid,
    input  logic [NREQ*D-1:0] ReqAddr,
    input  logic [NREQ*W-1:0] ReqData,
    output logic [NREQ-1:0]   ReqGrant,
    input  logic             IssueEn,
    input  logic [D-1:0]      IssueAddr,
    input  logic [D-1:0]      ReadAddrA,
    input  logic [D-1:0]      ReadAddrB,
    output logic             Stall,
    output logic             RegWriteEn,
    output logic [D-1:0]      WriteAddr,
    output logic [W-1:0]      WriteData,
    output logic [2**D-1:0]   Busy
);

    localparam int            AW      = $clog2(AGE_MAX + 1);
    localparam logic [AW-1:0] AGE_TOP = AW'(AGE_MAX);

    logic [NREQ-1:0][AW-1:0] age;
    logic [NREQ-1:0]         aged;
    logic [NREQ-1:0]         pool;
    logic [NREQ-1:0]         grant;
    logic [D-1:0]            sel_addr;
    logic [W-1:0]            sel_data;

    always_comb begin
        for (int i = 0; i < NREQ; i++)
            aged[i] = ReqValid[i] && (age[i] == AGE_TOP);
    end

    // Aged-out requesters form the candidate pool when present; otherwise all valid ones.
    always_comb begin
        pool  = (|aged) ? aged : ReqValid;
        grant = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (pool[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
        if (!Reset_n)
            grant = '0;
    end

    assign ReqGrant = grant;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_addr = ReqAddr[i*D +: D];
                sel_data = ReqData[i*W +: W];
            end
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_age
        always_ff @(posedge Clk or negedge Reset_n) begin
            if (!Reset_n)
                age[g] <= '0;
            else if (ReqValid[g] && !grant[g]) begin
                if (age[g] != AGE_TOP)
                    age[g] <= age[g] + 1'b1;
            end
            else
                age[g] <= '0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            RegWriteEn <= 1'b0;
            WriteAddr  <= '0;
            WriteData  <= '0;
        end
        else begin
            RegWriteEn <= |grant;
            if (|grant) begin
                WriteAddr <= sel_addr;
                WriteData <= sel_data;
            end
        end
    end

    rf_scoreboard #(.D(D)) u_sb (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .IssueEn    (IssueEn),
        .IssueAddr  (IssueAddr),
        .ReadAddrA  (ReadAddrA),
        .ReadAddrB  (ReadAddrB),
        .CommitEn   (RegWriteEn),
        .CommitAddr (WriteAddr),
        .Stall      (Stall),
        .Busy       (Busy)
    );

endmodule

// File: tb/tb_rf_write_sched.sv
// Directed bench for rf_write_sched: reset, single write, priority, aging,
// RAW stall through commit, set/clear collision and reset during a write.
module tb_rf_write_sched;

    logic        Clk;
    logic        Reset_n;
    logic [2:0]  ReqValid;
    logic [11:0] ReqAddr;
    logic [23:0] ReqData;
    logic [2:0]  ReqGrant;
    logic        IssueEn;
    logic [3:0]  IssueAddr;
    logic [3:0]  ReadAddrA;
    logic [3:0]  ReadAddrB;
    logic        Stall;
    logic        RegWriteEn;
    logic [3:0]  WriteAddr;
    logic [7:0]  WriteData;
    logic [15:0] Busy;

    int n_chk  = 0;
    int n_fail = 0;

    rf_write_sched dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .ReqValid   (ReqValid),
        .ReqAddr    (ReqAddr),
        .ReqData    (ReqData),
        .ReqGrant   (ReqGrant),
        .IssueEn    (IssueEn),
        .IssueAddr  (IssueAddr),
        .ReadAddrA  (ReadAddrA),
        .ReadAddrB  (ReadAddrB),
        .Stall      (Stall),
        .RegWriteEn (RegWriteEn),
        .WriteAddr  (WriteAddr),
        .WriteData  (WriteData),
        .Busy       (Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [3:0] a, input logic [7:0] d);
        ReqAddr[i*4 +: 4] = a;
        ReqData[i*8 +: 8] = d;
    endtask

    initial begin
        Reset_n   = 1'b0;
        ReqValid  = 3'b111;
        ReqAddr   = '0;
        ReqData   = '0;
        IssueEn   = 1'b0;
        IssueAddr = '0;
        ReadAddrA = '0;
        ReadAddrB = '0;
        tick();
        tick();

        // Reset state
        chk("rst_grant", ReqGrant, 3'b000);
        chk("rst_we", RegWriteEn, 1'b0);
        chk("rst_waddr", WriteAddr, 4'd0);
        chk("rst_wdata", WriteData, 8'h00);
        chk("rst_busy", Busy, 16'h0000);
        ReqValid = 3'b000;
        Reset_n  = 1'b1;
        tick();

        // Single write from the ALU
        ReqValid = 3'b010;
        set_req(1, 4'd3, 8'h3C);
        #1 chk("single_grant", ReqGrant, 3'b010);
        tick();
        ReqValid = 3'b000;
        chk("single_we", RegWriteEn, 1'b1);
        chk("single_waddr", WriteAddr, 4'd3);
        chk("single_wdata", WriteData, 8'h3C);
        tick();
        chk("single_we_off", RegWriteEn, 1'b0);
        chk("single_hold_addr", WriteAddr, 4'd3);
        chk("single_hold_data", WriteData, 8'h3C);

        // Priority: all valid, all ages 0
        ReqValid = 3'b111;
        set_req(0, 4'd1, 8'h11);
        set_req(1, 4'd2, 8'h22);
        set_req(2, 4'd3, 8'h33);
        #1 chk("prio_grant", ReqGrant, 3'b001);
        tick();
        ReqValid = 3'b000;
        chk("prio_waddr", WriteAddr, 4'd1);
        chk("prio_wdata", WriteData, 8'h11);
        tick();

        // Aging: load streams new data each cycle, immediate waits 3 cycles
        ReqValid = 3'b101;
        set_req(2, 4'd9, 8'h99);
        set_req(0, 4'd8, 8'hD0);
        #1 chk("age_c0_grant", ReqGrant, 3'b001);
        tick();
        chk("age_c0_wdata", WriteData, 8'hD0);
        set_req(0, 4'd8, 8'hD1);
        #1 chk("age_c1_grant", ReqGrant, 3'b001);
        tick();
        chk("age_c1_wdata", WriteData, 8'hD1);
        set_req(0, 4'd8, 8'hD2);
        #1 chk("age_c2_grant", ReqGrant, 3'b001);
        tick();
        chk("age_c2_wdata", WriteData, 8'hD2);
        set_req(0, 4'd8, 8'hD3);
        #1 chk("age_c3_grant", ReqGrant, 3'b100);
        tick();
        chk("age_c3_waddr", WriteAddr, 4'd9);
        chk("age_c3_wdata", WriteData, 8'h99);
        #1 chk("age_cleared_grant", ReqGrant, 3'b001);
        tick();
        chk("age_c4_wdata", WriteData, 8'hD3);
        ReqValid = 3'b000;
        tick();

        // RAW hazard on r7
        IssueEn   = 1'b1;
        IssueAddr = 4'd7;
        ReadAddrA = 4'd1;
        ReadAddrB = 4'd2;
        #1 chk("raw_issue_ok", Stall, 1'b0);
        tick();
        chk("raw_busy7", Busy, 16'h0080);
        IssueAddr = 4'd10;
        ReadAddrA = 4'd7;
        ReadAddrB = 4'd0;
        #1 chk("raw_stall", Stall, 1'b1);
        tick();
        chk("raw_stall_no_set", Busy, 16'h0080);
        ReqValid = 3'b010;
        set_req(1, 4'd7, 8'h77);
        #1 chk("raw_wr_grant", ReqGrant, 3'b010);
        tick();
        ReqValid = 3'b000;
        chk("raw_commit_we", RegWriteEn, 1'b1);
        chk("raw_commit_stall", Stall, 1'b1);
        chk("raw_commit_busy", Busy, 16'h0080);
        tick();
        chk("raw_after_busy", Busy, 16'h0000);
        chk("raw_after_stall", Stall, 1'b0);
        tick();
        chk("raw_issue10_busy", Busy, 16'h0400);

        // Set/clear collision on r4
        IssueAddr = 4'd4;
        ReadAddrA = 4'd0;
        ReadAddrB = 4'd0;
        tick();
        IssueEn = 1'b0;
        chk("col_busy4", Busy, 16'h0410);
        ReqValid = 3'b010;
        set_req(1, 4'd4, 8'h44);
        tick();
        ReqValid = 3'b000;
        IssueEn  = 1'b1;
        chk("col_commit_waddr", WriteAddr, 4'd4);
        #1 chk("col_waw_stall", Stall, 1'b1);
        tick();
        chk("col_busy_cleared", Busy, 16'h0400);
        chk("col_retry_stall", Stall, 1'b0);
        tick();
        IssueEn = 1'b0;
        chk("col_retry_busy", Busy, 16'h0410);

        // Reset during a back-to-back write
        ReqValid = 3'b010;
        set_req(1, 4'd5, 8'hA5);
        tick();
        chk("rstw_we_before", RegWriteEn, 1'b1);
        Reset_n = 1'b0;
        #1;
        chk("rstw_grant", ReqGrant, 3'b000);
        chk("rstw_we", RegWriteEn, 1'b0);
        chk("rstw_busy", Busy, 16'h0000);
        chk("rstw_waddr", WriteAddr, 4'd0);
        ReqValid = 3'b000;
        tick();
        Reset_n = 1'b1;
        tick();
        chk("rstw_no_write", RegWriteEn, 1'b0);
        chk("rstw_no_data", WriteData, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
